// File: rtl/noc_config_pkg.sv
// Shared definitions for the configuration-network target tile.
// Holds field widths, request/response message layouts, the command
// encoding and the register-file size used by the target and its bus.
package noc_config_pkg;

  localparam int ModuleAddressSize        = 11;
  localparam int CommandFieldSize         = 2;
  localparam int RegisterAddressFieldSize = 5;
  localparam int PayloadFieldSize         = 32;
  localparam int NumberOfRegisters        = 16;
  localparam int ErrCntSize               = 8;
  localparam int RequestSize  = CommandFieldSize + RegisterAddressFieldSize + PayloadFieldSize;
  localparam int ResponseSize = ModuleAddressSize + PayloadFieldSize;

  // Field offsets (LSB of each field) inside the flat messages
  localparam int ReqPayloadLsb = 0;
  localparam int ReqAddrLsb    = PayloadFieldSize;
  localparam int ReqCmdLsb     = PayloadFieldSize + RegisterAddressFieldSize;
  localparam int RespDataLsb   = 0;
  localparam int RespSrcLsb    = PayloadFieldSize;

  // Only two encodings are legal; 2'b10 and 2'b11 are rejected
  typedef enum logic [CommandFieldSize-1:0] {
    CMD_WRITE = 2'b00,
    CMD_READ  = 2'b01
  } cmd_e;

  typedef struct packed {
    logic [CommandFieldSize-1:0]         cmd;
    logic [RegisterAddressFieldSize-1:0] addr;
    logic [PayloadFieldSize-1:0]         payload;
  } request_msg_t;

  typedef struct packed {
    logic [ModuleAddressSize-1:0] src;
    logic [PayloadFieldSize-1:0]  data;
  } response_msg_t;

  // One extra bit keeps the compare exact even when the register count
  // equals the full address space
  function automatic logic addr_in_range(logic [RegisterAddressFieldSize-1:0] a);
    return {1'b0, a} < (RegisterAddressFieldSize+1)'(NumberOfRegisters);
  endfunction

endpackage

// File: rtl/noc_config_filereg_target_if.sv
// Request/response handshake between the NI and the config target.
//   master : NI side  (drives requests, consumes responses)
//   slave  : target   (accepts requests, produces responses)
interface noc_config_filereg_target_if;
  import noc_config_pkg::*;

  logic                         req_valid_i;
  logic                         req_ready_o;
  logic [RequestSize-1:0]       req_data_i;
  logic [ModuleAddressSize-1:0] req_src_i;
  logic                         resp_valid_o;
  logic                         resp_ready_i;
  logic [ResponseSize-1:0]      resp_data_o;

  modport master (
    output req_valid_i, req_data_i, req_src_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_src_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o
  );
endinterface

// File: rtl/noc_config_regfile.sv
// Router configuration register file.
//   addr_i    : shared read/write register address
//   we_i      : write strobe (caller already qualified with addr_ok_o)
//   wdata_i   : write data
//   rdata_o   : combinational read data, zero when addr is out of range
//   addr_ok_o : addr_i < NumberOfRegisters
//   regs_o    : flattened registers, reg i at [i*32 +: 32]
module noc_config_regfile
  import noc_config_pkg::*;
(
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [RegisterAddressFieldSize-1:0]           addr_i,
  input  logic                                          we_i,
  input  logic [PayloadFieldSize-1:0]                   wdata_i,
  output logic [PayloadFieldSize-1:0]                   rdata_o,
  output logic                                          addr_ok_o,
  output logic [NumberOfRegisters*PayloadFieldSize-1:0] regs_o
);
  localparam int IdxW = $clog2(NumberOfRegisters);

  logic [NumberOfRegisters-1:0][PayloadFieldSize-1:0] regs_q;
  logic [IdxW-1:0] idx;

  assign idx       = addr_i[IdxW-1:0];
  assign addr_ok_o = addr_in_range(addr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 regs_q      <= '0;
    else if (we_i && addr_ok_o)  regs_q[idx] <= wdata_i;
  end

  assign rdata_o = addr_ok_o ? regs_q[idx] : '0;
  assign regs_o  = regs_q;
endmodule

// File: rtl/noc_config_filereg_target.sv
// Configuration-network target endpoint.
// Accepts single-flit requests from the NI, applies writes to the local
// register file (pulsing cfg_we_o), answers reads with {src, data}, and
// counts illegal requests (bad command or out-of-range address).
//   clk_i, rst_ni : clock, async active-low reset
//   bus           : request/response handshake (slave side)
//   cfg_regs_o    : flattened register file to the router
//   cfg_we_o      : one-cycle pulse per applied write
//   cfg_addr_o    : address of the last applied write
//   err_cnt_o     : saturating illegal-request count
module noc_config_filereg_target
  import noc_config_pkg::*;
(
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  noc_config_filereg_target_if.slave                    bus,
  output logic [NumberOfRegisters*PayloadFieldSize-1:0] cfg_regs_o,
  output logic                                          cfg_we_o,
  output logic [RegisterAddressFieldSize-1:0]           cfg_addr_o,
  output logic [ErrCntSize-1:0]                         err_cnt_o
);
  typedef enum logic {IDLE, RESP} state_e;

  state_e        state_q, state_d;
  request_msg_t  req;
  response_msg_t resp_q;
  logic [PayloadFieldSize-1:0] rdata;
  logic addr_ok, accept, do_write, do_read, err_hit;
  logic cfg_we_q;
  logic [RegisterAddressFieldSize-1:0] cfg_addr_q;
  logic [ErrCntSize-1:0] err_q;

  assign req = request_msg_t'(bus.req_data_i);

  // Gated by rst_ni so the NI sees no ready while reset is held
  assign bus.req_ready_o  = (state_q == IDLE) && rst_ni;
  assign bus.resp_valid_o = (state_q == RESP);
  assign bus.resp_data_o  = resp_q;

  noc_config_regfile u_regfile (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .addr_i    (req.addr),
    .we_i      (do_write),
    .wdata_i   (req.payload),
    .rdata_o   (rdata),
    .addr_ok_o (addr_ok),
    .regs_o    (cfg_regs_o)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    do_write = 1'b0;
    do_read  = 1'b0;
    err_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        accept = bus.req_valid_i;
        if (accept) begin
          if (req.cmd == CMD_WRITE) begin
            do_write = addr_ok;
            err_hit  = !addr_ok;
          end else if (req.cmd == CMD_READ) begin
            // Out-of-range reads still answer (regfile returns zero)
            do_read  = 1'b1;
            err_hit  = !addr_ok;
            state_d  = RESP;
          end else begin
            err_hit  = 1'b1;
          end
        end
      end
      RESP: if (bus.resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      resp_q     <= '0;
      cfg_we_q   <= 1'b0;
      cfg_addr_q <= '0;
      err_q      <= '0;
    end else begin
      state_q  <= state_d;
      cfg_we_q <= do_write;
      if (do_write) cfg_addr_q <= req.addr;
      if (do_read)  resp_q     <= '{src: bus.req_src_i, data: rdata};
      if (err_hit && err_q != '1) err_q <= err_q + 1'b1;
    end
  end

  assign cfg_we_o   = cfg_we_q;
  assign cfg_addr_o = cfg_addr_q;
  assign err_cnt_o  = err_q;
endmodule

// File: tb/tb_noc_config_filereg_target.sv
module tb_noc_config_filereg_target;
  import noc_config_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [NumberOfRegisters*PayloadFieldSize-1:0] cfg_regs;
  logic cfg_we;
  logic [RegisterAddressFieldSize-1:0] cfg_addr;
  logic [ErrCntSize-1:0] err_cnt;

  int tests = 0;
  int fails = 0;

  noc_config_filereg_target_if bus();

  noc_config_filereg_target dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .bus        (bus.slave),
    .cfg_regs_o (cfg_regs),
    .cfg_we_o   (cfg_we),
    .cfg_addr_o (cfg_addr),
    .err_cnt_o  (err_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // Present one request for one edge (caller ensures target is in IDLE)
  task automatic send(input logic [1:0] cmd, input logic [4:0] addr,
                      input logic [31:0] pl, input logic [10:0] src);
    bus.req_valid_i = 1'b1;
    bus.req_data_i  = {cmd, addr, pl};
    bus.req_src_i   = src;
    step();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic consume();
    bus.resp_ready_i = 1'b1;
    step();
    bus.resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready_low got=%b exp=0", bus.req_ready_o); end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1; #1;
    tests++; if (bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready_o); end
    tests++; if (bus.resp_valid_o !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid_o); end
    tests++; if (cfg_regs !== '0) begin fails++; $display("FAIL rst_regs got=%h exp=0", cfg_regs); end
    tests++; if (err_cnt !== 8'h00 || cfg_we !== 1'b0) begin fails++; $display("FAIL rst_err_we got=%h/%b exp=00/0", err_cnt, cfg_we); end
    step();
  endtask

  task automatic test_write_read();
    send(2'b00, 5'd3, 32'hCAFE_0001, 11'h000);
    tests++; if (cfg_we !== 1'b1 || cfg_addr !== 5'd3) begin fails++; $display("FAIL wr_pulse got we=%b addr=%0d exp we=1 addr=3", cfg_we, cfg_addr); end
    tests++; if (cfg_regs[127:96] !== 32'hCAFE_0001) begin fails++; $display("FAIL wr_reg3 got=%h exp=cafe0001", cfg_regs[127:96]); end
    send(2'b01, 5'd3, 32'h0, 11'h05A);
    tests++; if (cfg_we !== 1'b0) begin fails++; $display("FAIL wr_pulse_end got=%b exp=0", cfg_we); end
    tests++; if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== {11'h05A, 32'hCAFE_0001}) begin
      fails++; $display("FAIL rd_reg3 got v=%b d=%h exp v=1 d=%h", bus.resp_valid_o, bus.resp_data_o, {11'h05A, 32'hCAFE_0001}); end
    consume();
    tests++; if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL rd_done got v=%b r=%b exp v=0 r=1", bus.resp_valid_o, bus.req_ready_o); end
  endtask

  task automatic test_stall();
    send(2'b01, 5'd3, 32'h0, 11'h7FF);
    // Offer a write to reg 5 during the stall; it must not be taken
    bus.req_valid_i = 1'b1;
    bus.req_data_i  = {2'b00, 5'd5, 32'h1234_5678};
    for (int c = 0; c < 5; c++) begin
      tests++; if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== {11'h7FF, 32'hCAFE_0001} || bus.req_ready_o !== 1'b0) begin
        fails++; $display("FAIL stall_c%0d got v=%b d=%h r=%b exp v=1 d=%h r=0", c, bus.resp_valid_o, bus.resp_data_o, bus.req_ready_o, {11'h7FF, 32'hCAFE_0001}); end
      step();
    end
    bus.req_valid_i = 1'b0;
    consume();
    tests++; if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL stall_exit got v=%b r=%b exp v=0 r=1", bus.resp_valid_o, bus.req_ready_o); end
    tests++; if (cfg_regs[191:160] !== 32'h0) begin fails++; $display("FAIL stall_no_write got=%h exp=0", cfg_regs[191:160]); end
  endtask

  task automatic test_errors();
    send(2'b00, 5'd20, 32'hFFFF_FFFF, 11'h000);
    tests++; if (cfg_we !== 1'b0 || err_cnt !== 8'd1) begin fails++; $display("FAIL err_wr_oor got we=%b cnt=%0d exp we=0 cnt=1", cfg_we, err_cnt); end
    send(2'b11, 5'd2, 32'h1, 11'h000);
    tests++; if (cfg_we !== 1'b0 || bus.resp_valid_o !== 1'b0 || err_cnt !== 8'd2) begin
      fails++; $display("FAIL err_cmd got we=%b v=%b cnt=%0d exp we=0 v=0 cnt=2", cfg_we, bus.resp_valid_o, err_cnt); end
    send(2'b01, 5'd17, 32'h0, 11'h001);
    tests++; if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== {11'h001, 32'h0} || err_cnt !== 8'd3) begin
      fails++; $display("FAIL err_rd_oor got v=%b d=%h cnt=%0d exp v=1 d=%h cnt=3", bus.resp_valid_o, bus.resp_data_o, err_cnt, {11'h001, 32'h0}); end
    consume();
    bus.req_valid_i = 1'b1;
    bus.req_data_i  = {2'b10, 5'd0, 32'h0};
    repeat (300) step();
    bus.req_valid_i = 1'b0;
    tests++; if (err_cnt !== 8'hFF || bus.resp_valid_o !== 1'b0) begin fails++; $display("FAIL err_sat got cnt=%h v=%b exp cnt=ff v=0", err_cnt, bus.resp_valid_o); end
    tests++; if (cfg_regs[127:96] !== 32'hCAFE_0001) begin fails++; $display("FAIL err_regs_kept got=%h exp=cafe0001", cfg_regs[127:96]); end
  endtask

  task automatic test_back_to_back();
    bus.req_valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.req_data_i = {2'b00, 5'(i), 32'(i) * 32'h1111};
      step();
      tests++; if (cfg_we !== 1'b1 || cfg_addr !== 5'(i)) begin fails++; $display("FAIL b2b_we%0d got we=%b addr=%0d exp we=1 addr=%0d", i, cfg_we, cfg_addr, i); end
    end
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(2'b01, 5'(i), 32'h0, 11'(i + 100));
      tests++; if (bus.resp_data_o !== {11'(i + 100), 32'(i) * 32'h1111} || bus.resp_valid_o !== 1'b1) begin
        fails++; $display("FAIL b2b_rd%0d got v=%b d=%h exp d=%h", i, bus.resp_valid_o, bus.resp_data_o, {11'(i + 100), 32'(i) * 32'h1111}); end
      consume();
    end
  endtask

  task automatic test_raw();
    // Write then read the same register on consecutive edges
    bus.req_valid_i = 1'b1;
    bus.req_src_i   = 11'h123;
    bus.req_data_i  = {2'b00, 5'd9, 32'hDEAD_BEEF};
    step();
    bus.req_data_i  = {2'b01, 5'd9, 32'h0};
    step();
    bus.req_valid_i = 1'b0;
    tests++; if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== {11'h123, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL raw got v=%b d=%h exp d=%h", bus.resp_valid_o, bus.resp_data_o, {11'h123, 32'hDEAD_BEEF}); end
  endtask

  task automatic test_reset_mid_resp();
    // Response from test_raw is still pending here
    #2 rst_ni = 1'b0; #1;
    tests++; if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL midrst_async got v=%b r=%b exp v=0 r=0", bus.resp_valid_o, bus.req_ready_o); end
    tests++; if (cfg_regs !== '0 || err_cnt !== 8'h00) begin fails++; $display("FAIL midrst_clear got cnt=%h regs_nz=%b exp 0", err_cnt, |cfg_regs); end
    @(negedge clk_i); rst_ni = 1'b1;
    step();
    tests++; if (bus.req_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin fails++; $display("FAIL midrst_ready got r=%b v=%b exp r=1 v=0", bus.req_ready_o, bus.resp_valid_o); end
    send(2'b01, 5'd9, 32'h0, 11'h0AA);
    tests++; if (bus.resp_data_o !== {11'h0AA, 32'h0}) begin fails++; $display("FAIL midrst_rd got=%h exp=%h", bus.resp_data_o, {11'h0AA, 32'h0}); end
    consume();
  endtask

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_data_i   = '0;
    bus.req_src_i    = '0;
    bus.resp_ready_i = 1'b0;
    test_reset();
    test_write_read();
    test_stall();
    test_errors();
    test_back_to_back();
    test_raw();
    test_reset_mid_resp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
